// File: rtl/pipe_regfile_pkg.sv
// Shared types and default configuration for the pipelined register file.
package pipe_regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 4;
    localparam int PC_IDX_DEF   = 15;
    localparam int RESET_PC_DEF = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/pipe_regfile_if.sv
// Bus between decode/writeback (master) and the register file (slave).
interface pipe_regfile_if
    import pipe_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    // Writeback port
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    // Decode read ports
    logic              re;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd_valid;
    // Program counter
    logic              pc_ld;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] pc_out;
    logic              pc_redirect;
    // Issue reservations and hazard lookups
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              hazard1;
    logic              hazard2;

    modport master (
        output we, wa, wd, re, ra1, ra2, pc_ld, pc_in, rsv_en, rsv_addr,
        input  rd1, rd2, rd_valid, pc_out, pc_redirect, hazard1, hazard2
    );

    modport slave (
        input  we, wa, wd, re, ra1, ra2, pc_ld, pc_in, rsv_en, rsv_addr,
        output rd1, rd2, rd_valid, pc_out, pc_redirect, hazard1, hazard2
    );

endinterface

// File: rtl/pipe_regfile_scoreboard.sv
// Per-register busy vector: issue reserves a destination, writeback frees it.
// With REGFILE_WR_BYPASS_EN defined, a same-cycle write to a read address
// masks that read's hazard, since the data is being forwarded.
module pipe_regfile_scoreboard
    import pipe_regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PC_IDX = PC_IDX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              hazard1,
    output logic              hazard2
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: clear on writeback, then set on reservation so set wins.
    always_comb begin
        // NOTE: default first so every path assigns busy_d and no latch is inferred.
        busy_d = busy_q;
        if (we) begin
            busy_d[wa] = 1'b0;
        end
        if (rsv_en && (rsv_addr != PC_ADDR)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    assign hazard1 = busy_q[ra1] && !(we && (wa == ra1));
    assign hazard2 = busy_q[ra2] && !(we && (wa == ra2));
`else
    assign hazard1 = busy_q[ra1];
    assign hazard2 = busy_q[ra2];
`endif

endmodule

// File: rtl/pipe_regfile.sv
// Pipelined register file: one write port, two registered read ports, a
// dedicated PC entry with redirect pulse, and a busy scoreboard.
// Optional macro REGFILE_WR_BYPASS_EN forwards same-cycle write data to reads.
module pipe_regfile
    import pipe_regfile_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                PC_IDX   = PC_IDX_DEF,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF)
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_regfile_if.slave  bus
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

    if (PC_IDX < 0 || PC_IDX >= DEPTH) begin : g_bad_pc_idx
        $error("pipe_regfile: PC_IDX %0d outside 0..%0d", PC_IDX, DEPTH - 1);
    end

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              rd_valid_q, rd_valid_d;
    logic              redirect_q, redirect_d;

    logic              wr_pc;
    logic              wr_gen;
    logic [DATA_W-1:0] src1, src2;
    logic [DATA_W-1:0] fwd1, fwd2;

    assign wr_pc  = bus.we && (bus.wa == PC_ADDR);
    assign wr_gen = bus.we && (bus.wa != PC_ADDR);

    // The PC slot of regs_q is never written; the PC lives in pc_q.
    assign src1 = (bus.ra1 == PC_ADDR) ? pc_q : regs_q[bus.ra1];
    assign src2 = (bus.ra2 == PC_ADDR) ? pc_q : regs_q[bus.ra2];

`ifdef REGFILE_WR_BYPASS_EN
    assign fwd1 = (bus.we && (bus.wa == bus.ra1)) ? bus.wd : src1;
    assign fwd2 = (bus.we && (bus.wa == bus.ra2)) ? bus.wd : src2;
`else
    assign fwd1 = src1;
    assign fwd2 = src2;
`endif

    // Next-state for PC (write port beats pc_ld), read data and status flags.
    always_comb begin
        pc_d       = pc_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        rd_valid_d = bus.re;
        redirect_d = wr_pc;
        if (wr_pc) begin
            pc_d = bus.wd;
        end else if (bus.pc_ld) begin
            pc_d = bus.pc_in;
        end
        if (bus.re) begin
            rd1_d = fwd1;
            rd2_d = fwd2;
        end
    end

    // General register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because software expects every register
            // to read 0 after reset; this keeps it in flops rather than a RAM.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_gen) begin
            regs_q[bus.wa] <= bus.wd;
        end
    end

    // PC entry, read data and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rd1_q      <= '0;
            rd2_q      <= '0;
            rd_valid_q <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            rd_valid_q <= rd_valid_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.rd1         = rd1_q;
    assign bus.rd2         = rd2_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.pc_out      = pc_q;
    assign bus.pc_redirect = redirect_q;

    pipe_regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .PC_IDX (PC_IDX)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .we       (bus.we),
        .wa       (bus.wa),
        .ra1      (bus.ra1),
        .ra2      (bus.ra2),
        .hazard1  (bus.hazard1),
        .hazard2  (bus.hazard2)
    );

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: reset sequence, vector table with a
// read-result queue, and a hold check. Follows REGFILE_WR_BYPASS_EN.
module tb_pipe_regfile;
    import pipe_regfile_pkg::*;

`ifdef REGFILE_WR_BYPASS_EN
    localparam logic [31:0] COL_R5 = 32'hAA;
    localparam logic [31:0] COL_PC = 32'h300;
    localparam logic        H_COL  = 1'b0;
`else
    localparam logic [31:0] COL_R5 = 32'h11;
    localparam logic [31:0] COL_PC = 32'h204;
    localparam logic        H_COL  = 1'b1;
`endif

    typedef struct {
        string     name;
        logic      we;
        reg_addr_t wa;
        reg_data_t wd;
        logic      re;
        reg_addr_t ra1;
        reg_addr_t ra2;
        logic      pc_ld;
        reg_data_t pc_in;
        logic      rsv_en;
        reg_addr_t rsv_addr;
        logic      h1;
        logic      h2;
        reg_data_t rd1;
        reg_data_t rd2;
        logic      valid;
        reg_data_t pc;
        logic      redir;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    logic [63:0] exp_q [$];
    vec_t vecs [18];

    pipe_regfile_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    pipe_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic idle_inputs();
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.re = 1'b0; bus.ra1 = '0; bus.ra2 = '0;
        bus.pc_ld = 1'b0; bus.pc_in = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    endtask

    task automatic apply(input vec_t v);
        logic [63:0] e;
        @(negedge clk);
        bus.we = v.we; bus.wa = v.wa; bus.wd = v.wd;
        bus.re = v.re; bus.ra1 = v.ra1; bus.ra2 = v.ra2;
        bus.pc_ld = v.pc_ld; bus.pc_in = v.pc_in;
        bus.rsv_en = v.rsv_en; bus.rsv_addr = v.rsv_addr;
        #1;
        check({v.name, " hazard1"}, 32'(bus.hazard1), 32'(v.h1));
        check({v.name, " hazard2"}, 32'(bus.hazard2), 32'(v.h2));
        if (v.re) exp_q.push_back({v.rd1, v.rd2});
        @(posedge clk);
        #1;
        check({v.name, " rd_valid"}, 32'(bus.rd_valid), 32'(v.valid));
        check({v.name, " pc_out"}, bus.pc_out, v.pc);
        check({v.name, " pc_redirect"}, 32'(bus.pc_redirect), 32'(v.redir));
        if (bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                check({v.name, " rd_valid_without_read"}, 32'(bus.rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({v.name, " rd1"}, bus.rd1, e[63:32]);
                check({v.name, " rd2"}, bus.rd2, e[31:0]);
            end
        end
    endtask

    initial begin
        //            name             we wa     wd             re ra1    ra2    ld pc_in     rs raddr  h1     h2    rd1            rd2            v     pc         redir
        vecs[0]  = '{"wr_r2",          1, 4'd2,  32'h12345678,  0, 4'd0,  4'd0,  0, 32'h0,    0, 4'd0,  0,     0,    32'h0,         32'h0,         0,    32'h0,     0};
        vecs[1]  = '{"rd_r2",          0, 4'd0,  32'h0,         1, 4'd2,  4'd0,  0, 32'h0,    0, 4'd0,  0,     0,    32'h12345678,  32'h0,         1,    32'h0,     0};
        vecs[2]  = '{"pc_ld",          0, 4'd0,  32'h0,         0, 4'd0,  4'd0,  1, 32'h100,  0, 4'd0,  0,     0,    32'h0,         32'h0,         0,    32'h100,   0};
        vecs[3]  = '{"pc_redirect",    1, 4'd15, 32'h200,       0, 4'd0,  4'd0,  1, 32'h104,  0, 4'd0,  0,     0,    32'h0,         32'h0,         0,    32'h200,   1};
        vecs[4]  = '{"redirect_end",   0, 4'd0,  32'h0,         1, 4'd15, 4'd2,  0, 32'h0,    0, 4'd0,  0,     0,    32'h200,       32'h12345678,  1,    32'h200,   0};
        vecs[5]  = '{"wr_r5",          1, 4'd5,  32'h11,        0, 4'd0,  4'd0,  0, 32'h0,    0, 4'd0,  0,     0,    32'h0,         32'h0,         0,    32'h200,   0};
        vecs[6]  = '{"collide_r5",     1, 4'd5,  32'hAA,        1, 4'd5,  4'd15, 0, 32'h0,    0, 4'd0,  0,     0,    COL_R5,        32'h200,       1,    32'h200,   0};
        vecs[7]  = '{"rd_r5",          0, 4'd0,  32'h0,         1, 4'd5,  4'd5,  0, 32'h0,    0, 4'd0,  0,     0,    32'hAA,        32'hAA,        1,    32'h200,   0};
        vecs[8]  = '{"rsv_r7",         0, 4'd0,  32'h0,         0, 4'd7,  4'd7,  0, 32'h0,    1, 4'd7,  0,     0,    32'h0,         32'h0,         0,    32'h200,   0};
        vecs[9]  = '{"haz_r7",         0, 4'd0,  32'h0,         0, 4'd7,  4'd3,  0, 32'h0,    0, 4'd0,  1,     0,    32'h0,         32'h0,         0,    32'h200,   0};
        vecs[10] = '{"rsv_and_wr_r7",  1, 4'd7,  32'h77,        0, 4'd7,  4'd0,  0, 32'h0,    1, 4'd7,  H_COL, 0,    32'h0,         32'h0,         0,    32'h200,   0};
        vecs[11] = '{"still_busy_r7",  0, 4'd0,  32'h0,         1, 4'd7,  4'd7,  0, 32'h0,    0, 4'd0,  1,     1,    32'h77,        32'h77,        1,    32'h200,   0};
        vecs[12] = '{"clr_r7",         1, 4'd7,  32'h78,        0, 4'd7,  4'd0,  0, 32'h0,    0, 4'd0,  H_COL, 0,    32'h0,         32'h0,         0,    32'h200,   0};
        vecs[13] = '{"free_r7",        0, 4'd0,  32'h0,         1, 4'd7,  4'd7,  0, 32'h0,    0, 4'd0,  0,     0,    32'h78,        32'h78,        1,    32'h200,   0};
        vecs[14] = '{"rsv_r15",        0, 4'd0,  32'h0,         0, 4'd15, 4'd7,  0, 32'h0,    1, 4'd15, 0,     0,    32'h0,         32'h0,         0,    32'h200,   0};
        vecs[15] = '{"pc_not_busy",    0, 4'd0,  32'h0,         0, 4'd15, 4'd15, 1, 32'h204,  0, 4'd0,  0,     0,    32'h0,         32'h0,         0,    32'h204,   0};
        vecs[16] = '{"pc_collide",     1, 4'd15, 32'h300,       1, 4'd15, 4'd2,  1, 32'h208,  0, 4'd0,  0,     0,    COL_PC,        32'h12345678,  1,    32'h300,   1};
        vecs[17] = '{"rd_hold",        0, 4'd0,  32'h0,         0, 4'd0,  4'd0,  0, 32'h0,    0, 4'd0,  0,     0,    32'h0,         32'h0,         0,    32'h300,   0};

        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Put some state in, then assert reset mid-write and release.
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 4'd3; bus.wd = 32'h55;
        bus.pc_ld = 1'b1; bus.pc_in = 32'h40;
        @(posedge clk); #1;
        check("pre_reset pc_out", bus.pc_out, 32'h40);
        @(negedge clk);
        idle_inputs();
        bus.we = 1'b1; bus.wa = 4'd3; bus.wd = 32'hDEAD;
        bus.re = 1'b1; bus.ra1 = 4'd3;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset pc_out", bus.pc_out, 32'h0);
        check("async_reset rd_valid", 32'(bus.rd_valid), 32'd0);
        check("async_reset pc_redirect", 32'(bus.pc_redirect), 32'd0);
        check("async_reset rd1", bus.rd1, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        bus.ra1 = 4'd3; bus.ra2 = 4'd7;
        #1;
        check("after_reset hazard1", 32'(bus.hazard1), 32'd0);
        check("after_reset hazard2", 32'(bus.hazard2), 32'd0);
        @(negedge clk);
        bus.re = 1'b1;
        @(posedge clk); #1;
        check("after_reset r3", bus.rd1, 32'h0);
        check("after_reset rd_valid", 32'(bus.rd_valid), 32'd1);
        check("after_reset pc_out", bus.pc_out, 32'h0);
        @(negedge clk);
        idle_inputs();

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i]);
        end

        // With re low the previous read data must be held.
        check("hold rd1", bus.rd1, COL_PC);
        check("hold rd2", bus.rd2, 32'h12345678);
        check("read_queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
